// File: rtl/vedic_mul8_sequencer_if.sv
// rtl/vedic_mul8_sequencer_if.sv - operand, partial-product and result bundle for the 8x8 Vedic sequencer
interface vedic_mul8_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  modport slave (
    input  in_valid, a, b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, p, busy
  );

  modport master (
    output in_valid, a, b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, p, busy
  );
endinterface

// File: rtl/vedic_mul8_sequencer.sv
// rtl/vedic_mul8_sequencer.sv - 8x8 unsigned multiply in four passes through an external 4x4 Vedic multiplier
module vedic_mul8_sequencer #(
  parameter int ZERO_SKIP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vedic_mul8_sequencer_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_LH   = 3'd2,
    S_HL   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;

  logic        accept;
  logic        skip;

  assign accept = io.in_valid && (state_q == S_IDLE);
  assign skip   = (ZERO_SKIP != 0) && ((io.a == 8'h00) || (io.b == 8'h00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    io.mul_a = 4'h0;
    io.mul_b = 4'h0;

    // Each pass weights the returned partial product by its nibble position.
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = io.a;
          b_d     = io.b;
          acc_d   = 16'h0000;
          state_d = skip ? S_DONE : S_LL;
        end
      end
      S_LL: begin
        io.mul_a = a_q[3:0];
        io.mul_b = b_q[3:0];
        acc_d    = acc_q + {8'h00, io.mul_p};
        state_d  = S_LH;
      end
      S_LH: begin
        io.mul_a = a_q[7:4];
        io.mul_b = b_q[3:0];
        acc_d    = acc_q + {4'h0, io.mul_p, 4'h0};
        state_d  = S_HL;
      end
      S_HL: begin
        io.mul_a = a_q[3:0];
        io.mul_b = b_q[7:4];
        acc_d    = acc_q + {4'h0, io.mul_p, 4'h0};
        state_d  = S_HH;
      end
      S_HH: begin
        io.mul_a = a_q[7:4];
        io.mul_b = b_q[7:4];
        acc_d    = acc_q + {io.mul_p, 8'h00};
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.busy      = (state_q != S_IDLE);
  assign io.p         = acc_q;

endmodule

// File: tb/tb_vedic_mul8_sequencer.sv
// tb/tb_vedic_mul8_sequencer.sv - directed self-checking bench for vedic_mul8_sequencer
module tb_vedic_mul8_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vedic_mul8_sequencer_if if0 ();
  vedic_mul8_sequencer_if if1 ();

  // Behavioural stand-in for the external 4x4 Vedic multiplier.
  assign if0.mul_p = {4'h0, if0.mul_a} * {4'h0, if0.mul_b};
  assign if1.mul_p = {4'h0, if1.mul_a} * {4'h0, if1.mul_b};

  vedic_mul8_sequencer #(.ZERO_SKIP(1)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0.slave));
  vedic_mul8_sequencer #(.ZERO_SKIP(0)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1.slave));

  logic [3:0] tr_ma [8];
  logic [3:0] tr_mb [8];
  logic [7:0] tr_mp [8];
  int         tr_n;
  int         lat;
  time        acc_time;

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    int n = 0;
    while (if0.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL start_op_in_ready_timeout got %b want 1", if0.in_ready);
    end
    if0.in_valid = 1'b1;
    if0.a = av;
    if0.b = bv;
    @(posedge clk);
    acc_time = $time;
    #1;
    if0.in_valid = 1'b0;
    if0.a = 8'hEE;
    if0.b = 8'h11;
  endtask

  task automatic wait_done();
    lat  = 1;
    tr_n = 0;
    @(negedge clk);
    while (if0.out_valid !== 1'b1 && lat < 20) begin
      if (tr_n < 8) begin
        tr_ma[tr_n] = if0.mul_a;
        tr_mb[tr_n] = if0.mul_b;
        tr_mp[tr_n] = if0.mul_p;
      end
      tr_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.a = 8'h00; if0.b = 8'h00;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a = 8'h00; if1.b = 8'h00;
    #12;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", if0.in_ready); end
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", if0.out_valid); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if0.busy); end
    checks++; if (if0.p !== 16'h0000) begin errors++; $display("FAIL reset_p got %h want 0000", if0.p); end
    checks++; if (if0.mul_a !== 4'h0 || if0.mul_b !== 4'h0) begin
      errors++; $display("FAIL reset_mul got %h/%h want 0/0", if0.mul_a, if0.mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    exp_a = '{4'h3, 4'h0, 4'h3, 4'h0};
    exp_b = '{4'h5, 4'h5, 4'h0, 4'h0};
    start_op(8'h03, 8'h05);
    wait_done();
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++; if (tr_n != 4) begin errors++; $display("FAIL basic_passes got %0d want 4", tr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_ma[i] !== exp_a[i] || tr_mb[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL basic_nibbles[%0d] got (%h,%h) want (%h,%h)", i, tr_ma[i], tr_mb[i], exp_a[i], exp_b[i]);
      end
    end
    checks++; if (if0.p !== 16'h000F) begin errors++; $display("FAIL basic_p got %h want 000f", if0.p); end
    checks++; if (if0.busy !== 1'b1 || if0.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done_flags got busy=%b in_ready=%b want 1/0", if0.busy, if0.in_ready);
    end
    finish_op();
  endtask

  task automatic test_partials();
    logic [7:0] exp_p [4];
    exp_p = '{8'h54, 8'h46, 8'h24, 8'h1E};
    start_op(8'hAC, 8'h37);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr_mp[i] !== exp_p[i]) begin
        errors++; $display("FAIL partial_mul_p[%0d] got %h want %h", i, tr_mp[i], exp_p[i]);
      end
    end
    checks++; if (if0.p !== 16'h24F4) begin errors++; $display("FAIL partial_p got %h want 24f4", if0.p); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    time t1;
    start_op(8'hFF, 8'hFF);
    t1 = acc_time;
    wait_done();
    checks++; if (if0.p !== 16'hFE01) begin errors++; $display("FAIL b2b_max_p got %h want fe01", if0.p); end
    finish_op();
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", if0.in_ready); end
    start_op(8'h0A, 8'h0C);
    checks++; if ((acc_time - t1) != 60) begin
      errors++; $display("FAIL b2b_interval got %0t want 60", acc_time - t1);
    end
    wait_done();
    checks++; if (if0.p !== 16'h0078) begin errors++; $display("FAIL b2b_second_p got %h want 0078", if0.p); end
    finish_op();
  endtask

  task automatic test_zero_skip();
    start_op(8'h00, 8'h5A);
    wait_done();
    checks++; if (lat != 1) begin errors++; $display("FAIL skip_latency got %0d want 1", lat); end
    checks++; if (tr_n != 0) begin errors++; $display("FAIL skip_passes got %0d want 0", tr_n); end
    checks++; if (if0.mul_a !== 4'h0 || if0.mul_b !== 4'h0) begin
      errors++; $display("FAIL skip_mul got %h/%h want 0/0", if0.mul_a, if0.mul_b);
    end
    checks++; if (if0.p !== 16'h0000) begin errors++; $display("FAIL skip_p got %h want 0000", if0.p); end
    finish_op();
    start_op(8'h5A, 8'h00);
    wait_done();
    checks++; if (lat != 1 || if0.p !== 16'h0000) begin
      errors++; $display("FAIL skip_b_zero got lat=%0d p=%h want 1/0000", lat, if0.p);
    end
    finish_op();
  endtask

  task automatic test_no_skip();
    int n;
    if1.in_valid = 1'b1;
    if1.a = 8'h00;
    if1.b = 8'h5A;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (if1.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL noskip_latency got %0d want 5", n); end
    checks++; if (if1.p !== 16'h0000) begin errors++; $display("FAIL noskip_p got %h want 0000", if1.p); end
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL noskip_in_ready got %b want 1", if1.in_ready); end
  endtask

  task automatic test_backpressure();
    start_op(8'h12, 8'h34);
    wait_done();
    checks++; if (if0.p !== 16'h03A8) begin errors++; $display("FAIL bp_p got %h want 03a8", if0.p); end
    for (int i = 0; i < 7; i++) begin
      if0.in_valid = 1'b1;
      if0.a = 8'($urandom_range(1, 255));
      if0.b = 8'($urandom_range(1, 255));
      @(negedge clk);
      checks++;
      if (if0.p !== 16'h03A8 || if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got p=%h in_ready=%b out_valid=%b want 03a8/0/1", i, if0.p, if0.in_ready, if0.out_valid);
      end
    end
    if0.in_valid = 1'b0;
    finish_op();
    checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", if0.out_valid, if0.in_ready);
    end
    start_op(8'h02, 8'h03);
    wait_done();
    checks++; if (if0.p !== 16'h0006 || lat != 5) begin
      errors++; $display("FAIL bp_next got p=%h lat=%0d want 0006/5", if0.p, lat);
    end
    finish_op();
  endtask

  task automatic test_async_reset();
    int seen;
    start_op(8'h9B, 8'h6D);
    repeat (3) @(negedge clk);
    checks++; if (if0.mul_a !== 4'hB || if0.mul_b !== 4'h6) begin
      errors++; $display("FAIL areset_hl_nibbles got %h/%h want b/6", if0.mul_a, if0.mul_b);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.in_ready !== 1'b1 || if0.busy !== 1'b0 || if0.out_valid !== 1'b0 ||
        if0.p !== 16'h0000 || if0.mul_a !== 4'h0 || if0.mul_b !== 4'h0) begin
      errors++;
      $display("FAIL areset_outputs got in_ready=%b busy=%b out_valid=%b p=%h mul=%h/%h want 1/0/0/0000/0/0",
               if0.in_ready, if0.busy, if0.out_valid, if0.p, if0.mul_a, if0.mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if0.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL areset_no_out_valid got %0d want 0", seen); end
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b want 1", if0.in_ready); end
    start_op(8'h9B, 8'h6D);
    wait_done();
    checks++; if (if0.p !== 16'h41FF) begin errors++; $display("FAIL areset_rerun_p got %h want 41ff", if0.p); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partials();
    test_back_to_back();
    test_zero_skip();
    test_no_skip();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule
